// File: rtl/fifo_sync_param.sv
// Single-clock parameterised FIFO with registered or first-word-fall-through read port.
// Define FIFO_SYNC_PARAM_ERR_FLAG_EN to build the sticky overflow/underflow flags.
module fifo_sync_param #(
  parameter int ADDR_WIDTH       = 10,
  parameter int DATA_WIDTH       = 32,
  parameter int FWFT             = 0,
  parameter int ALMOST_FULL_NUM  = 11,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   water_level,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LVL_AF   = (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [ADDR_WIDTH:0] LVL_AE   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);
  localparam logic [ADDR_WIDTH:0] LVL_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance uses the registered flags, so a full FIFO drops the write even if a read frees a slot.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; reset only clears pointers, so stale words are unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  assign water_level  = level;
  assign full         = (level == LVL_FULL);
  assign empty        = (level == '0);
  assign almost_full  = (level >= LVL_AF);
  assign almost_empty = (level <= LVL_AE);

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data = mem[rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;
      always_ff @(posedge clk) begin
        if (rst)         rd_data_q <= '0;
        else if (rd_acc) rd_data_q <= mem[rd_ptr];
      end
      assign rd_data = rd_data_q;
    end
  endgenerate

`ifdef FIFO_SYNC_PARAM_ERR_FLAG_EN
  // A set event in the same cycle as err_clr wins because it is assigned last.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (err_clr) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule
